// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode and
// ping-pong direction encodings, reused by the mode controllers.
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_COUNT    = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled and flags the wrap edge.
// clr restarts the period; it wins over en.
module tick_gen #(
    parameter int unsigned DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// N-LED pattern driver with four selectable patterns and a step strobe.
// All outputs come straight from registers.
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int unsigned LED_NUM  = 4,
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] leds,
    output logic               step
);

    mode_t              mode_in, mode_q, mode_d;
    dir_t               dir_q, dir_d;
    logic [LED_NUM-1:0] leds_q, leds_d;
    logic               step_q, step_d;
    logic               mode_change;
    logic               tick;

    assign mode_in     = mode_t'(mode);
    assign mode_change = (mode_in != mode_q);

    function automatic logic [LED_NUM-1:0] init_of(input mode_t m);
        return (m == MODE_ROTATE || m == MODE_PINGPONG) ? LED_NUM'(1) : '0;
    endfunction

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (mode_change),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_ROTATE;
            dir_q  <= DIR_UP;
            leds_q <= LED_NUM'(1);
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            step_q <= step_d;
        end
    end

    // A mode change restarts the pattern and swallows a coincident tick.
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        step_d = 1'b0;
        if (mode_change) begin
            mode_d = mode_in;
            dir_d  = DIR_UP;
            leds_d = init_of(mode_in);
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_ROTATE: begin
                    if (!$onehot(leds_q))
                        leds_d = init_of(mode_q);
                    else
                        leds_d = (leds_q << 1) | (leds_q >> (LED_NUM - 1));
                end
                MODE_PINGPONG: begin
                    if (!$onehot(leds_q)) begin
                        leds_d = init_of(mode_q);
                        dir_d  = DIR_UP;
                    end else if (LED_NUM == 1) begin
                        leds_d = leds_q;
                    end else if (dir_q == DIR_UP) begin
                        // Turning at the MSB also moves one place in the same step.
                        if (leds_q[LED_NUM-1]) begin
                            dir_d  = DIR_DOWN;
                            leds_d = leds_q >> 1;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            dir_d  = DIR_UP;
                            leds_d = leds_q << 1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                MODE_COUNT: leds_d = leds_q + LED_NUM'(1);
                MODE_BLINK: leds_d = ~leds_q;
                default:    leds_d = init_of(mode_q);
            endcase
        end
    end

    always_comb begin
        leds = leds_q;
        step = step_q;
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_NUM=4, TICK_DIV=4 on a 50 MHz clock.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] leds;
    logic       step;

    int unsigned n_checks;
    int unsigned n_fail;

    led_pattern_gen #(.LED_NUM(4), .TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .leds  (leds),
        .step  (step)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Waits (bounded) for the next step pulse; checks its distance in clocks and leds.
    task automatic wait_step(input string tag, input logic [3:0] exp_leds, input int exp_gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < 40);
        check({tag, "_gap"}, n, exp_gap);
        check({tag, "_leds"}, {28'd0, leds}, {28'd0, exp_leds});
    endtask

    initial begin
        logic [3:0] pp_seq [7];
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd0;

        // 1: reset state and rotate
        #50;
        check("rst_leds", {28'd0, leds}, 32'h1);
        check("rst_step", {31'd0, step}, 32'h0);
        #45 rst_n = 1'b1;
        @(negedge clk);
        check("rel_leds", {28'd0, leds}, 32'h1);
        wait_step("rot1", 4'b0010, 4);
        wait_step("rot2", 4'b0100, 4);
        wait_step("rot3", 4'b1000, 4);
        wait_step("rot4", 4'b0001, 4);

        // 2: ping-pong
        mode = 2'd1;
        @(negedge clk);
        check("pp_init", {28'd0, leds}, 32'h1);
        check("pp_init_step", {31'd0, step}, 32'h0);
        pp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        for (int i = 0; i < 7; i++) wait_step($sformatf("pp%0d", i), pp_seq[i], 4);

        // 3: binary count with wrap
        mode = 2'd2;
        @(negedge clk);
        check("cnt_init", {28'd0, leds}, 32'h0);
        for (int i = 0; i < 16; i++) wait_step($sformatf("cnt%0d", i), 4'((i + 1) % 16), 4);

        // 4: blink, then mode change one clock before a tick
        mode = 2'd3;
        @(negedge clk);
        check("blk_init", {28'd0, leds}, 32'h0);
        wait_step("blk1", 4'b1111, 4);
        wait_step("blk2", 4'b0000, 4);
        wait_step("blk3", 4'b1111, 4);
        repeat (3) @(negedge clk);
        mode = 2'd0;
        @(negedge clk);
        check("mchg_leds", {28'd0, leds}, 32'h1);
        check("mchg_step", {31'd0, step}, 32'h0);
        wait_step("mchg_adv", 4'b0010, 4);

        // 5: freeze two clocks into a period
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("frz_leds%0d", i), {28'd0, leds}, 32'h2);
            check($sformatf("frz_step%0d", i), {31'd0, step}, 32'h0);
        end
        en = 1'b1;
        wait_step("frz_resume", 4'b0100, 2);

        // 6: asynchronous reset between clock edges
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_leds", {28'd0, leds}, 32'h1);
        check("arst_step", {31'd0, step}, 32'h0);
        #3 rst_n = 1'b1;
        wait_step("arst_adv1", 4'b0010, 4);
        wait_step("arst_adv2", 4'b0100, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
